// File: rtl/midi_in_pkg.sv
// Shared types for the MIDI input arbiter.
//   midi_byte_t : one buffered MIDI byte with its side fields (24 bits)
//   arb_state_t : arbiter FSM states, also exported on the debug port
package midi_in_pkg;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] byte_nr;
    logic [7:0] data;
  } midi_byte_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/midi_in_arbiter_if.sv
// Bus bundle between the MIDI byte sources / configuration and the arbiter.
//   merge_en, static_sel          : mode select (round-robin merge or one fixed source)
//   src_byteready                 : per-source one-cycle byte strobe
//   src_cur_status/_midibyte_nr/_midi_in_data : per-source fields, valid with strobe
//   byteready                     : one-cycle strobe of the merged output byte
//   cur_status/midibyte_nr/midi_in_data : fields of the last output byte, held
//   grant_src                     : source of the current or last output byte
//   overflow                      : sticky per-source drop flag
//
// Handshake: strobe-only, no backpressure. A byte is transferred on every rising
// edge where its strobe is high; the receiver must take it in that cycle. Input
// bytes that cannot be buffered are dropped and flagged on overflow.
interface midi_in_arbiter_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic                    merge_en;
  logic [SEL_W-1:0]        static_sel;
  logic [NUM_SRC-1:0]      src_byteready;
  logic [NUM_SRC-1:0][7:0] src_cur_status;
  logic [NUM_SRC-1:0][7:0] src_midibyte_nr;
  logic [NUM_SRC-1:0][7:0] src_midi_in_data;
  logic                    byteready;
  logic [7:0]              cur_status;
  logic [7:0]              midibyte_nr;
  logic [7:0]              midi_in_data;
  logic [SEL_W-1:0]        grant_src;
  logic [NUM_SRC-1:0]      overflow;

  modport master (
    output merge_en, static_sel, src_byteready,
           src_cur_status, src_midibyte_nr, src_midi_in_data,
    input  byteready, cur_status, midibyte_nr, midi_in_data, grant_src, overflow
  );

  modport slave (
    input  merge_en, static_sel, src_byteready,
           src_cur_status, src_midibyte_nr, src_midi_in_data,
    output byteready, cur_status, midibyte_nr, midi_in_data, grant_src, overflow
  );
endinterface

// File: rtl/midi_byte_fifo.sv
// Per-source FIFO of MIDI bytes.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : empties the FIFO (same effect as reset on pointers/count)
//   push/push_data : write request; accepted when not full, or when full and
//                    a pop happens in the same cycle
//   pop/pop_data   : read request; pop_data shows the head entry combinationally
//   full/empty     : occupancy flags
module midi_byte_fifo
  import midi_in_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  midi_byte_t push_data,
  input  logic       pop,
  output midi_byte_t pop_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  midi_byte_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           wr_en;
  logic           rd_en;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_en    = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/midi_in_arbiter.sv
// Merges NUM_SRC MIDI byte streams into one. Each source is buffered in its own
// FIFO; an arbiter locks onto one source and drains it, keeps the lock for
// HOLD_CYC idle cycles so a message in progress is not interleaved, then moves
// round-robin to the next non-empty source (or only static_sel in static mode).
//   reg_clk, reset_reg : clock, synchronous active-high reset
//   bus                : source/config inputs and merged outputs (slave side)
//   state_dbg          : current arbiter state
module midi_in_arbiter
  import midi_in_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_CYC   = 64
) (
  input  logic              reg_clk,
  input  logic              reset_reg,
  midi_in_arbiter_if.slave  bus,
  output arb_state_t        state_dbg
);
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);
  localparam logic [SEL_W:0] NSRC = (SEL_W+1)'(NUM_SRC);

  // Mode-change detection. These track the inputs even during reset so the
  // first edge after reset never sees a spurious change.
  logic             merge_q;
  logic [SEL_W-1:0] sel_q;
  logic             chg;

  always_ff @(posedge reg_clk) begin
    merge_q <= bus.merge_en;
    sel_q   <= bus.static_sel;
  end

  assign chg = (bus.merge_en != merge_q) || (bus.static_sel != sel_q);

  // Per-source FIFOs
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  midi_byte_t         wr_data [NUM_SRC];
  midi_byte_t         rd_data [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign en[i]   = bus.merge_en || (bus.static_sel == SEL_W'(i));
    // Pushes are discarded while disabled or during a mode-change cycle.
    assign push[i] = bus.src_byteready[i] && en[i] && !chg;
    assign wr_data[i] = '{status:  bus.src_cur_status[i],
                          byte_nr: bus.src_midibyte_nr[i],
                          data:    bus.src_midi_in_data[i]};

    midi_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (reg_clk),
      .rst       (reset_reg),
      .flush     (chg),
      .push      (push[i]),
      .push_data (wr_data[i]),
      .pop       (pop[i]),
      .pop_data  (rd_data[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  // Round-robin search starting one past 'from'; MSB of the result = found.
  function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] from,
                                             input logic [NUM_SRC-1:0] req);
    logic [SEL_W:0] res;
    logic [SEL_W:0] idx;
    res = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      idx = {1'b0, from} + (SEL_W+1)'(off + 1);
      if (idx >= NSRC) idx = idx - NSRC;
      if (!res[SEL_W] && req[idx[SEL_W-1:0]]) res = {1'b1, idx[SEL_W-1:0]};
    end
    return res;
  endfunction

  // Arbiter FSM
  arb_state_t       state, state_n;
  logic [HC_W-1:0]  hold_cnt, hold_cnt_n;
  logic [SEL_W-1:0] grant, grant_n;
  logic [SEL_W:0]   pick;
  logic             push_g;
  logic             empty_g;

  assign pick    = rr_pick(grant, en & ~empty);
  assign push_g  = push[grant];
  assign empty_g = empty[grant];

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      state    <= IDLE;
      hold_cnt <= '0;
      grant    <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      grant    <= grant_n;
    end
  end

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    grant_n    = grant;
    if (chg) begin
      state_n    = IDLE;
      hold_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[SEL_W]) begin
            grant_n = pick[SEL_W-1:0];
            state_n = LOCKED;
          end
        end
        LOCKED: begin
          // A push landing on the empty FIFO this edge keeps us draining.
          if (empty_g && !push_g) begin
            state_n    = HOLD;
            hold_cnt_n = HC_W'(HOLD_CYC);
          end
        end
        HOLD: begin
          // Non-empty also counts so a byte pushed on the LOCKED->HOLD edge
          // is not stranded.
          if (push_g || !empty_g) begin
            state_n = LOCKED;
          end else if (hold_cnt <= HC_W'(1)) begin
            state_n    = IDLE;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_cnt - 1'b1;
          end
        end
        default: begin
          state_n    = IDLE;
          hold_cnt_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    pop = '0;
    if (state == LOCKED && !chg && !empty_g) pop[grant] = 1'b1;
  end

  assign state_dbg = state;

  // Output path: popped entry is staged one cycle, then presented with the
  // strobe. A mode change kills a staged byte as well as the buffered ones.
  logic             s_valid;
  midi_byte_t       s_data;
  logic [SEL_W-1:0] s_src;
  logic             br_q;
  midi_byte_t       out_q;
  logic [SEL_W-1:0] out_src;
  logic [NUM_SRC-1:0] ovf_q;

  always_ff @(posedge reg_clk) begin
    if (reset_reg) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_src   <= '0;
      br_q    <= 1'b0;
      out_q   <= '0;
      out_src <= '0;
      ovf_q   <= '0;
    end else begin
      s_valid <= |pop;
      s_data  <= rd_data[grant];
      s_src   <= grant;
      br_q    <= s_valid && !chg;
      if (s_valid && !chg) begin
        out_q   <= s_data;
        out_src <= s_src;
      end
      ovf_q <= ovf_q | (push & full & ~pop);
    end
  end

  assign bus.byteready    = br_q;
  assign bus.cur_status   = out_q.status;
  assign bus.midibyte_nr  = out_q.byte_nr;
  assign bus.midi_in_data = out_q.data;
  assign bus.grant_src    = out_src;
  assign bus.overflow     = ovf_q;

endmodule
